serial_pattern_tx: RTL and testbench

Serial bit-stream transmitter for the 1010 sequence detector path. It accepts a parallel word through a ready/load handshake and shifts it onto the single-bit `go` line, one bit per clock, with a programmable inter-word gap. A built-in Moore tracker counts every overlapping 1010 occurrence it puts on the line. That count is the golden reference for checking the detector's `get` output.

---
 rtl/serial_pattern_tx_pkg.sv | 13 +
 rtl/serial_pattern_tx_pattern_tracker.sv | 39 +++
 rtl/serial_pattern_tx.sv | 107 ++++++++++
 tb/tb_serial_pattern_tx.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/serial_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM state encoding
// and the 4-bit sequence the on-line tracker looks for.
package serial_pattern_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam logic [3:0] PATTERN = 4'b1010;

endpackage

// File: rtl/serial_pattern_tx_pattern_tracker.sv
// Moore tracker: shifts in every registered go bit, flags the 1010 sequence
// (oldest bit first) and keeps a saturating count of flagged cycles.
module serial_pattern_tx_pattern_tracker
  import serial_pattern_tx_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  output logic             pat_hit,
  output logic [CNT_W-1:0] pat_cnt
);

  logic [3:0]       hist_q, hist_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign pat_hit = (hist_q == PATTERN);
  assign pat_cnt = cnt_q;

  always_comb begin
    hist_d = {hist_q[2:0], go};
    cnt_d  = cnt_q;
    if (pat_hit && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial word transmitter: loads a parallel word on load&&ready and shifts it
// onto go one bit per clock, followed by GAP idle cycles, with a 1010 tracker.
module serial_pattern_tx
  import serial_pattern_tx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int GAP       = 2,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             go,
  output logic             busy,
  output logic             done,
  output logic             pat_hit,
  output logic [CNT_W-1:0] pat_cnt
);

  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [GW-1:0] LAST_GAP = GW'((GAP > 0) ? (GAP - 1) : 0);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             go_q, go_d;
  logic             last_bit;
  logic             accept;

  assign last_bit = (state_q == ST_SHIFT) && (bit_q == LAST_BIT);
  // With no gap the final bit cycle can accept the next word for a bubble-free stream.
  assign ready    = (state_q == ST_IDLE) || (last_bit && (GAP == 0));
  assign accept   = load && ready;
  assign go       = go_q;
  assign busy     = (state_q == ST_SHIFT) || (state_q == ST_GAP);
  assign done     = last_bit;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    go_d    = 1'b0;
    if (accept) begin
      state_d = ST_SHIFT;
      bit_d   = '0;
      go_d    = (MSB_FIRST != 0) ? data_in[WIDTH-1] : data_in[0];
      sreg_d  = (MSB_FIRST != 0) ? (data_in << 1) : (data_in >> 1);
    end else begin
      case (state_q)
        ST_SHIFT: begin
          if (last_bit) begin
            gap_d   = '0;
            state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
          end else begin
            bit_d  = bit_q + 1'b1;
            go_d   = (MSB_FIRST != 0) ? sreg_q[WIDTH-1] : sreg_q[0];
            sreg_d = (MSB_FIRST != 0) ? (sreg_q << 1) : (sreg_q >> 1);
          end
        end
        ST_GAP: begin
          if (gap_q == LAST_GAP) begin
            state_d = ST_IDLE;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      go_q    <= go_d;
    end
  end

  serial_pattern_tx_pattern_tracker #(
    .CNT_W(CNT_W)
  ) u_tracker (
    .clk    (clk),
    .rst    (rst),
    .go     (go_q),
    .pat_hit(pat_hit),
    .pat_cnt(pat_cnt)
  );

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: four parameterisations driven side by side,
// each with a stream-level reference model feeding a per-cycle scoreboard.
module tb_serial_pattern_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  int   phase = 0;
  int   checks = 0;
  int   passes = 0;

  logic [31:0] cnt_all;
  logic [3:0]  ready_all;
  logic [3:0]  busy_all;

  typedef struct packed {
    logic go;
    logic done;
    logic busy;
  } step_t;

  typedef struct {
    step_t s;
    logic  rdy;
    logic  hit;
    int    cnt;
  } exp_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Instance 0: defaults; 1: LSB first; 2: no gap; 3: no gap with 2-bit counter.
  for (genvar gi = 0; gi < 4; gi++) begin : g_inst
    localparam int GAP_P = (gi >= 2) ? 0 : 2;
    localparam int MSB_P = (gi == 1) ? 0 : 1;
    localparam int CW    = (gi == 3) ? 2 : 8;

    logic          load_r = 1'b1;
    logic [7:0]    data_r = 8'hFF;
    logic          ready, go, busy, done, hit;
    logic [CW-1:0] pc;
    exp_t          exp_q[$];
    exp_t          e;

    serial_pattern_tx #(
      .WIDTH(8), .GAP(GAP_P), .MSB_FIRST(MSB_P), .CNT_W(CW)
    ) u_dut (
      .clk(clk), .rst(rst), .data_in(data_r), .load(load_r),
      .ready(ready), .go(go), .busy(busy), .done(done),
      .pat_hit(hit), .pat_cnt(pc)
    );

    assign cnt_all[gi*8 +: 8] = 8'(pc);
    assign ready_all[gi]      = ready;
    assign busy_all[gi]       = busy;

    initial begin : model
      step_t      pend[$];
      step_t      cur;
      logic [3:0] hist;
      int         cnt;
      logic       rdy;
      int         ptr;
      int         nwords;
      int         kind;
      bit         fired;
      logic [7:0] words[3];
      cur = '0; hist = '0; cnt = 0; rdy = 1'b0; ptr = 0; kind = 0; fired = 0;
      words[0] = 8'hAA; words[1] = 8'hAA; words[2] = 8'hAA;
      case (gi)
        0: begin words[0] = 8'hA5; nwords = 1; end
        1: begin words[0] = 8'h05; nwords = 1; end
        2: nwords = 2;
        default: nwords = 3;
      endcase
      forever begin
        @(posedge clk);
        if (rst) begin
          pend.delete();
          cur = '0; hist = '0; cnt = 0;
        end else begin
          if (hist == 4'b1010 && cnt < (1 << CW) - 1) cnt++;
          hist = {hist[2:0], cur.go};
          if (load_r && rdy) begin
            for (int b = 0; b < 8; b++)
              pend.push_back(step_t'{go: (MSB_P != 0) ? data_r[7-b] : data_r[b],
                                     done: (b == 7), busy: 1'b1});
            for (int g = 0; g < GAP_P; g++)
              pend.push_back(step_t'{go: 1'b0, done: 1'b0, busy: 1'b1});
            if (kind == 1) ptr++;
            if (kind == 2) fired = 1;
          end
          if (pend.size() > 0) cur = pend.pop_front();
          else cur = '0;
        end
        rdy = (pend.size() == 0) && (!cur.busy || (cur.done && GAP_P == 0));
        exp_q.push_back('{s: cur, rdy: rdy, hit: (hist == 4'b1010), cnt: cnt});
        #1;
        kind = 0;
        case (phase)
          0: begin load_r = 1'b1; data_r = 8'hFF; end
          1: begin
            if (ptr < nwords && rdy) begin
              load_r = 1'b1; data_r = words[ptr]; kind = 1;
            end else if (ptr < nwords) begin
              load_r = 1'b1; data_r = 8'hFF;
            end else begin
              load_r = 1'b0;
            end
          end
          2: begin load_r = 1'($urandom_range(0, 1)); data_r = 8'($urandom); end
          3: begin
            if (!fired && rdy) begin
              load_r = 1'b1; data_r = 8'h96; kind = 2;
            end else begin
              load_r = 1'b0;
            end
          end
          default: load_r = 1'b0;
        endcase
      end
    end

    always @(negedge clk) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk($sformatf("u%0d.go", gi),      int'(go),    int'(e.s.go));
        chk($sformatf("u%0d.done", gi),    int'(done),  int'(e.s.done));
        chk($sformatf("u%0d.busy", gi),    int'(busy),  int'(e.s.busy));
        chk($sformatf("u%0d.ready", gi),   int'(ready), int'(e.rdy));
        chk($sformatf("u%0d.pat_hit", gi), int'(hit),   int'(e.hit));
        chk($sformatf("u%0d.pat_cnt", gi), int'(pc),    e.cnt);
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    phase = 1;
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("dir.u0.pat_cnt", int'(cnt_all[7:0]),   2);
    chk("dir.u1.pat_cnt", int'(cnt_all[15:8]),  1);
    chk("dir.u2.pat_cnt", int'(cnt_all[23:16]), 7);
    chk("dir.u3.pat_cnt", int'(cnt_all[31:24]), 3);
    chk("dir.ready_all",  int'(ready_all),      15);
    chk("dir.busy_all",   int'(busy_all),       0);
    $display("directed words done, pat_cnt=%h", cnt_all);

    phase = 2;
    repeat (400) @(negedge clk);
    phase = 9;
    repeat (20) @(negedge clk);
    $display("random stream done, pat_cnt=%h", cnt_all);

    phase = 3;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst.pat_cnt_all", int'(cnt_all),   0);
    chk("rst.busy_all",    int'(busy_all),  0);
    chk("rst.ready_all",   int'(ready_all), 15);
    $display("mid-word reset applied");
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
